// File: rtl/door_motor_sequencer_pkg.sv
// Shared types for the door motor sequencer: FSM states, travel direction,
// requester identity and the two-requester arbitration helper.
package door_pkg;

  typedef enum logic [2:0] {
    IDLE,
    MV_UP,
    MV_DOWN,
    DEAD,
    FAULT
  } state_t;

  typedef enum logic {
    UP,
    DOWN
  } dir_t;

  typedef enum logic {
    LOCAL,
    REMOTE
  } src_t;

  // A lone request wins outright; a collision goes to the round-robin side.
  function automatic src_t pick_winner(input logic req_local,
                                       input logic req_remote,
                                       input src_t rr_ptr);
    if (req_local && req_remote) return rr_ptr;
    else if (req_remote)         return REMOTE;
    else                         return LOCAL;
  endfunction

endpackage

// File: rtl/door_motor_sequencer_if.sv
// Request, sensor and motor-drive signal bundle between the door environment
// (master) and the motor sequencer (slave).
interface door_motor_sequencer_if;

  logic Req_Local;
  logic Req_Remote;
  logic Up_Max;
  logic Down_Max;
  logic Obstacle;
  logic Fault_Clr;
  logic Up_Motor;
  logic Down_Motor;
  logic Grant_Local;
  logic Grant_Remote;
  logic Busy;
  logic Fault;

  modport master (
    output Req_Local, Req_Remote, Up_Max, Down_Max, Obstacle, Fault_Clr,
    input  Up_Motor, Down_Motor, Grant_Local, Grant_Remote, Busy, Fault
  );

  modport slave (
    input  Req_Local, Req_Remote, Up_Max, Down_Max, Obstacle, Fault_Clr,
    output Up_Motor, Down_Motor, Grant_Local, Grant_Remote, Busy, Fault
  );

endinterface

// File: rtl/door_motor_sequencer_timer.sv
// Shared cycle counter for dead-time and run timeout; tc flags the last cycle
// of a window of 'limit' enabled cycles.
module door_cycle_timer #(
  parameter int unsigned CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clr,
  input  logic             en,
  input  logic [CNT_W-1:0] limit,
  output logic             tc
);

  logic [CNT_W-1:0] count;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count <= '0;
    end else if (clr) begin
      count <= '0;
    end else if (en) begin
      count <= count + CNT_W'(1);
    end
  end

  always_comb begin
    tc = en && (count == limit - CNT_W'(1));
  end

endmodule

// File: rtl/door_motor_sequencer.sv
// Door up/down motor sequencer: request arbitration, direction choice, dead-time
// and run watchdog. Optional macro OBSTACLE_REVERSE_EN enables auto-reverse.
module door_motor_sequencer
  import door_pkg::*;
#(
  parameter int unsigned DEADTIME_CYC = 4,
  parameter int unsigned TIMEOUT_CYC  = 1000,
  parameter int unsigned CNT_W        = 16
) (
  input logic                   CLK,
  input logic                   RST,
  door_motor_sequencer_if.slave door
);

  state_t           state;
  dir_t             last_dir;
  src_t             rr_ptr;
  src_t             winner;
  logic             up_motor;
  logic             down_motor;
  logic             grant_local;
  logic             grant_remote;
  logic             busy;
  logic             fault;
  logic             moving;
  logic             req_any;
  logic             req_both;
  logic             limit_hit;
  logic             obst_hit;
  logic             tmr_en;
  logic             tmr_clr;
  logic             tc;
  logic [CNT_W-1:0] tmr_limit;
`ifdef OBSTACLE_REVERSE_EN
  logic             rev_pending;
`endif

  // Timer is held clear outside motion/dead-time and on every state exit,
  // so each window starts from zero.
  always_comb begin
    moving    = (state == MV_UP) || (state == MV_DOWN);
    req_any   = door.Req_Local || door.Req_Remote;
    req_both  = door.Req_Local && door.Req_Remote;
    limit_hit = ((state == MV_UP) && door.Up_Max) ||
                ((state == MV_DOWN) && door.Down_Max);
    obst_hit  = (state == MV_DOWN) && door.Obstacle;
    tmr_en    = moving || (state == DEAD);
    tmr_clr   = !tmr_en || tc || (moving && (limit_hit || obst_hit || req_any));
    tmr_limit = (state == DEAD) ? CNT_W'(DEADTIME_CYC) : CNT_W'(TIMEOUT_CYC);
    winner    = pick_winner(door.Req_Local, door.Req_Remote, rr_ptr);
  end

  door_cycle_timer #(
    .CNT_W(CNT_W)
  ) u_timer (
    .clk  (CLK),
    .rst  (RST),
    .clr  (tmr_clr),
    .en   (tmr_en),
    .limit(tmr_limit),
    .tc   (tc)
  );

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state        <= IDLE;
      last_dir     <= DOWN;
      rr_ptr       <= LOCAL;
      up_motor     <= 1'b0;
      down_motor   <= 1'b0;
      grant_local  <= 1'b0;
      grant_remote <= 1'b0;
      busy         <= 1'b0;
      fault        <= 1'b0;
`ifdef OBSTACLE_REVERSE_EN
      rev_pending  <= 1'b0;
`endif
    end else begin
      grant_local  <= 1'b0;
      grant_remote <= 1'b0;
      unique case (state)
        IDLE: begin
          if (req_any) begin
            if (req_both) rr_ptr <= (rr_ptr == LOCAL) ? REMOTE : LOCAL;
            busy <= 1'b1;
            if (door.Up_Max && door.Down_Max) begin
              state <= FAULT;
              fault <= 1'b1;
            end else begin
              grant_local  <= (winner == LOCAL);
              grant_remote <= (winner == REMOTE);
              if (door.Up_Max || (!door.Down_Max && last_dir == UP)) begin
                state      <= MV_DOWN;
                down_motor <= 1'b1;
                last_dir   <= DOWN;
              end else begin
                state    <= MV_UP;
                up_motor <= 1'b1;
                last_dir <= UP;
              end
            end
          end
        end

        MV_UP, MV_DOWN: begin
          if (tc) begin
            state      <= FAULT;
            fault      <= 1'b1;
            up_motor   <= 1'b0;
            down_motor <= 1'b0;
`ifdef OBSTACLE_REVERSE_EN
            rev_pending <= 1'b0;
`endif
          end else if (limit_hit || obst_hit || req_any) begin
            state      <= DEAD;
            up_motor   <= 1'b0;
            down_motor <= 1'b0;
            if (!limit_hit && !obst_hit) begin
              grant_local  <= (winner == LOCAL);
              grant_remote <= (winner == REMOTE);
              if (req_both) rr_ptr <= (rr_ptr == LOCAL) ? REMOTE : LOCAL;
            end
`ifdef OBSTACLE_REVERSE_EN
            if (!limit_hit && obst_hit) rev_pending <= 1'b1;
`endif
          end
        end

        DEAD: begin
          if (tc) begin
`ifdef OBSTACLE_REVERSE_EN
            if (rev_pending) begin
              state       <= MV_UP;
              up_motor    <= 1'b1;
              last_dir    <= UP;
              rev_pending <= 1'b0;
            end else begin
              state <= IDLE;
              busy  <= 1'b0;
            end
`else
            state <= IDLE;
            busy  <= 1'b0;
`endif
          end
        end

        FAULT: begin
          if (door.Fault_Clr) begin
            state <= DEAD;
            fault <= 1'b0;
          end
        end

        default: begin
          state      <= IDLE;
          busy       <= 1'b0;
          fault      <= 1'b0;
          up_motor   <= 1'b0;
          down_motor <= 1'b0;
        end
      endcase
    end
  end

  always_comb begin
    door.Up_Motor     = up_motor;
    door.Down_Motor   = down_motor;
    door.Grant_Local  = grant_local;
    door.Grant_Remote = grant_remote;
    door.Busy         = busy;
    door.Fault        = fault;
  end

endmodule
